view_mode_sequencer: RTL

//  Selects which pipeline stage drives vga_driver: camera RGB, grey, Sobel edge, or edge with a centroid overlay.

---
 rtl/view_mode_sequencer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/view_mode_sequencer.sv
// Chooses the pixel source feeding vga_driver (RGB, grey, edge, edge+centroid marker),
// steps the mode on a debounced button press and commits it only at frame boundaries.
module view_mode_sequencer #(
  parameter int unsigned IMG_W        = 640,
  parameter int unsigned DEBOUNCE_CYC = 250000,
  parameter int unsigned MARK_HALF    = 2,
  parameter logic [1:0]  RESET_MODE   = 2'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        config_finished,
  input  logic        frame_tick,
  input  logic        mode_btn,
  input  logic [11:0] rgb_pix,
  input  logic        rgb_vld,
  input  logic [11:0] grey_pix,
  input  logic        grey_vld,
  input  logic [11:0] edge_pix,
  input  logic        edge_vld,
  input  logic [9:0]  centroid_x,
  input  logic        line_valid,
  input  logic        line_lost,
  output logic [11:0] out_pix,
  output logic        out_vld,
  output logic [1:0]  mode
);

  localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  localparam logic [1:0] ST_WAIT_CFG = 2'd0;
  localparam logic [1:0] ST_ARMED    = 2'd1;
  localparam logic [1:0] ST_RUN      = 2'd2;

  localparam logic [1:0] MODE_RGB     = 2'd0;
  localparam logic [1:0] MODE_GREY    = 2'd1;
  localparam logic [1:0] MODE_OVERLAY = 2'd3;

  logic [1:0]    state, state_nxt;
  logic [1:0]    pending;
  logic          btn_s1, btn_s2;
  logic          deb_level, deb_prev;
  logic [DW-1:0] deb_cnt;
  logic          press;
  logic [CW-1:0] col;
  logic [9:0]    cx_lat;
  logic          lv_lat, ll_lat;
  logic          src_vld;
  logic [11:0]   sel_pix;
  logic          in_span;
  logic          run_now;
  logic [10:0]   cx_w, col_w, span_lo, span_hi;

  // Button: two-flop synchroniser followed by a stability counter
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1    <= 1'b0;
      btn_s2    <= 1'b0;
      deb_level <= 1'b0;
      deb_prev  <= 1'b0;
      deb_cnt   <= '0;
    end else begin
      btn_s1   <= mode_btn;
      btn_s2   <= btn_s1;
      deb_prev <= deb_level;
      if (btn_s2 == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DW'(DEBOUNCE_CYC - 1)) begin
        deb_level <= btn_s2;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

  assign press = deb_level & ~deb_prev;

  // A press coincident with frame_tick commits the old pending value; the increment waits a frame
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= RESET_MODE;
      mode    <= RESET_MODE;
      cx_lat  <= '0;
      lv_lat  <= 1'b0;
      ll_lat  <= 1'b0;
    end else begin
      if (press)
        pending <= pending + 2'd1;
      if (frame_tick) begin
        mode   <= pending;
        cx_lat <= centroid_x;
        lv_lat <= line_valid;
        ll_lat <= line_lost;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_WAIT_CFG: if (config_finished) state_nxt = ST_ARMED;
      ST_ARMED: begin
        if (!config_finished) state_nxt = ST_WAIT_CFG;
        else if (frame_tick)  state_nxt = ST_RUN;
      end
      ST_RUN:    if (!config_finished) state_nxt = ST_WAIT_CFG;
      default:   state_nxt = ST_WAIT_CFG;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_WAIT_CFG;
    else     state <= state_nxt;
  end

  always_comb begin
    src_vld = edge_vld;
    sel_pix = edge_pix;
    case (mode)
      MODE_RGB:  begin src_vld = rgb_vld;  sel_pix = rgb_pix;  end
      MODE_GREY: begin src_vld = grey_vld; sel_pix = grey_pix; end
      default:   begin src_vld = edge_vld; sel_pix = edge_pix; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      col <= '0;
    else if (frame_tick)
      col <= '0;
    else if (src_vld)
      col <= (col == CW'(IMG_W - 1)) ? '0 : col + CW'(1);
  end

  // Marker span clamped to [0, IMG_W-1]; an off-screen centroid draws nothing
  always_comb begin
    cx_w    = {1'b0, cx_lat};
    col_w   = 11'(col);
    span_lo = (cx_w >= 11'(MARK_HALF)) ? cx_w - 11'(MARK_HALF) : '0;
    span_hi = ((cx_w + 11'(MARK_HALF)) > 11'(IMG_W - 1)) ? 11'(IMG_W - 1)
                                                        : cx_w + 11'(MARK_HALF);
    in_span = (cx_w < 11'(IMG_W)) && (col_w >= span_lo) && (col_w <= span_hi);
  end

  // A dropped config blanks the very next pixel, ahead of the state register catching up
  assign run_now = (state == ST_RUN) && config_finished;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_pix <= '0;
      out_vld <= 1'b0;
    end else begin
      out_vld <= src_vld;
      if (!run_now)
        out_pix <= 12'h000;
      else if (mode == MODE_OVERLAY && in_span && lv_lat)
        out_pix <= 12'h0F0;
      else if (mode == MODE_OVERLAY && in_span && ll_lat)
        out_pix <= 12'hF00;
      else
        out_pix <= sel_pix;
    end
  end

endmodule
